// File: rtl/ssd1306_spi4_master.sv
// rtl/ssd1306_spi4_master.sv - SPI 4-wire byte transmitter for an SSD1306 display.
// Buffers {dc, data} bytes in a FIFO and shifts each one out MSB-first in SPI mode 0.
module ssd1306_spi4_master #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_IDLE    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [7:0]                  data_i,
    input  logic                        dc_i,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        busy_o,
    output logic                        cs_on,
    output logic                        sck_o,
    output logic                        sdi_o,
    output logic                        dc_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, load;
    logic [8:0]    head;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [2:0]    bit_q, bit_d;
    logic [6:0]    sh_q, sh_d;
    logic          cs_q, cs_d, sck_q, sck_d, sdi_q, sdi_d, dc_q, dc_d;

    // Full means not ready even if the FSM pops in the same cycle.
    assign ready_o = !rst_i && (count_q < FULL_LVL);
    assign push    = valid_i && ready_o;
    assign head    = mem_q[rd_ptr_q];
    assign level_o = count_q;
    assign busy_o  = (state_q != IDLE) || (count_q != '0);
    assign cs_on   = cs_q;
    assign sck_o   = sck_q;
    assign sdi_o   = sdi_q;
    assign dc_o    = dc_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dc_i, data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        sdi_d   = sdi_q;
        dc_d    = dc_q;
        load    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) load = 1'b1;
            end
            SETUP: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            HIGH: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    sck_d   = 1'b0;
                    state_d = LOW;
                    // After bit 0 the LOW phase is a hold: data stays put.
                    if (bit_q != 3'd0) begin
                        sdi_d = sh_q[6];
                        sh_d  = {sh_q[5:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            LOW: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q != 3'd0) begin
                        bit_d   = bit_q - 3'd1;
                        sck_d   = 1'b1;
                        state_d = HIGH;
                    end else if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        cs_d    = 1'b1;
                        gap_d   = '0;
                        state_d = GAP;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = IDLE;
                else                   gap_d = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            pop     = 1'b1;
            sh_d    = head[6:0];
            sdi_d   = head[7];
            dc_d    = head[8];
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            bit_d   = 3'd7;
            phase_d = '0;
            state_d = SETUP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            gap_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            dc_q    <= dc_d;
        end
    end
endmodule
